// File: rtl/cache_ctrl_nway.sv
// Control FSM for the N-way set-associative, write-back, write-allocate data cache.
// Sequences tag check, dirty-victim writeback and refill, and drives the way-indexed array strobes.
module cache_ctrl_nway #(
    parameter int unsigned  WAYS        = 2,
    parameter int unsigned  MEM_TIMEOUT = 255,
    localparam int unsigned WW          = $clog2(WAYS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_read,
    input  logic            cpu_write,
    input  logic [WAYS-1:0] hit_way,
    input  logic [WAYS-1:0] is_valid,
    input  logic [WAYS-1:0] is_dirty,
    input  logic [WW-1:0]   lru_way,
    input  logic            mem_resp,
    output logic            cpu_ready,
    output logic [WAYS-1:0] load_data,
    output logic [WAYS-1:0] load_tag,
    output logic [WAYS-1:0] set_valid,
    output logic [WAYS-1:0] set_dirty,
    output logic [WAYS-1:0] clr_dirty,
    output logic            lru_update,
    output logic [WW-1:0]   lru_touch,
    output logic            data_in_select,
    output logic [WW-1:0]   wb_way,
    output logic            mem_read,
    output logic            mem_write,
    output logic            busy,
    output logic            error
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, REFILL} state_t;

    state_t          state, state_n;
    logic [WW-1:0]   victim, victim_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            op_write, op_write_n;

    logic [WW-1:0]   hit_idx;
    logic [WW-1:0]   pick;
    logic [WAYS-1:0] hit_oh;
    logic [WAYS-1:0] victim_oh;
    logic            hit_multi;
    logic            timeout;

    // Hit encode and victim pick: descending scan leaves the lowest matching index.
    always_comb begin : decode
        hit_idx   = '0;
        pick      = lru_way;
        hit_oh    = '0;
        victim_oh = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (hit_way[i])   hit_idx = WW'(i);
            if (!is_valid[i]) pick    = WW'(i);
        end
        hit_oh[hit_idx]   = 1'b1;
        victim_oh[victim] = 1'b1;
    end

    assign hit_multi = (hit_way & (hit_way - WAYS'(1))) != '0;
    // A response arriving on the deadline cycle takes precedence over the timeout.
    assign timeout   = (cnt == CW'(MEM_TIMEOUT)) && !mem_resp;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state    <= IDLE;
            victim   <= '0;
            cnt      <= '0;
            op_write <= 1'b0;
        end else begin
            state    <= state_n;
            victim   <= victim_n;
            cnt      <= cnt_n;
            op_write <= op_write_n;
        end
    end

    always_comb begin : next_state
        state_n        = state;
        victim_n       = victim;
        cnt_n          = cnt;
        op_write_n     = op_write;
        cpu_ready      = 1'b0;
        load_data      = '0;
        load_tag       = '0;
        set_valid      = '0;
        set_dirty      = '0;
        clr_dirty      = '0;
        lru_update     = 1'b0;
        lru_touch      = '0;
        data_in_select = 1'b0;
        wb_way         = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        error          = 1'b0;
        busy           = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (cpu_write || cpu_read) begin
                    op_write_n = cpu_write;
                    state_n    = CHECK;
                end
            end
            CHECK: begin
                cnt_n = '0;
                if (hit_multi) begin
                    error     = 1'b1;
                    cpu_ready = 1'b1;
                    state_n   = IDLE;
                end else if (|hit_way) begin
                    cpu_ready  = 1'b1;
                    lru_update = 1'b1;
                    lru_touch  = hit_idx;
                    if (op_write) begin
                        load_data = hit_oh;
                        set_dirty = hit_oh;
                    end
                    state_n = IDLE;
                end else begin
                    victim_n = pick;
                    state_n  = (is_valid[pick] && is_dirty[pick]) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                wb_way = victim;
                if (mem_resp) begin
                    mem_write = 1'b1;
                    cnt_n     = '0;
                    state_n   = REFILL;
                end else if (timeout) begin
                    error     = 1'b1;
                    cpu_ready = 1'b1;
                    state_n   = IDLE;
                end else begin
                    mem_write = 1'b1;
                    cnt_n     = cnt + CW'(1);
                end
            end
            REFILL: begin
                if (mem_resp) begin
                    mem_read       = 1'b1;
                    load_data      = victim_oh;
                    load_tag       = victim_oh;
                    set_valid      = victim_oh;
                    clr_dirty      = victim_oh;
                    data_in_select = 1'b1;
                    state_n        = CHECK;
                end else if (timeout) begin
                    error     = 1'b1;
                    cpu_ready = 1'b1;
                    state_n   = IDLE;
                end else begin
                    mem_read = 1'b1;
                    cnt_n    = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Randomised and directed bench for cache_ctrl_nway (WAYS=4, MEM_TIMEOUT=4).
// Expectations come from a transaction-level model of the miss/hit/timeout rules.
module tb_cache_ctrl_nway;

    localparam int unsigned WAYS = 4;
    localparam int unsigned WW   = 2;
    localparam int unsigned TMO  = 4;

    logic            clk;
    logic            rst;
    logic            cpu_read, cpu_write;
    logic [WAYS-1:0] hit_way, is_valid, is_dirty;
    logic [WW-1:0]   lru_way;
    logic            mem_resp;
    logic            cpu_ready, lru_update, data_in_select, mem_read, mem_write, busy, error;
    logic [WAYS-1:0] load_data, load_tag, set_valid, set_dirty, clr_dirty;
    logic [WW-1:0]   lru_touch, wb_way;

    typedef struct packed {
        logic            busy;
        logic            cpu_ready;
        logic            error;
        logic            lru_update;
        logic [WW-1:0]   lru_touch;
        logic [WAYS-1:0] load_data;
        logic [WAYS-1:0] load_tag;
        logic [WAYS-1:0] set_valid;
        logic [WAYS-1:0] set_dirty;
        logic [WAYS-1:0] clr_dirty;
        logic            data_in_select;
        logic [WW-1:0]   wb_way;
        logic            mem_read;
        logic            mem_write;
    } outs_t;

    outs_t obs;
    int    checks;
    int    errors;

    cache_ctrl_nway #(.WAYS(WAYS), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .hit_way(hit_way), .is_valid(is_valid), .is_dirty(is_dirty), .lru_way(lru_way),
        .mem_resp(mem_resp), .cpu_ready(cpu_ready), .load_data(load_data), .load_tag(load_tag),
        .set_valid(set_valid), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
        .lru_update(lru_update), .lru_touch(lru_touch), .data_in_select(data_in_select),
        .wb_way(wb_way), .mem_read(mem_read), .mem_write(mem_write), .busy(busy), .error(error)
    );

    assign obs = {busy, cpu_ready, error, lru_update, lru_touch, load_data, load_tag, set_valid,
                  set_dirty, clr_dirty, data_in_select, wb_way, mem_read, mem_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Victim rule: lowest-index invalid way, else the LRU way.
    function automatic int exp_victim(input logic [WAYS-1:0] vld, input logic [WW-1:0] lru);
        for (int i = 0; i < int'(WAYS); i++)
            if (!vld[i]) return i;
        return int'(lru);
    endfunction

    // Fields whose value is unspecified in a given cycle are masked out.
    function automatic outs_t loose_mask();
        outs_t m;
        m                = '1;
        m.lru_touch      = '0;
        m.wb_way         = '0;
        m.data_in_select = 1'b0;
        return m;
    endfunction

    task automatic scramble();
        hit_way  = WAYS'($urandom);
        is_valid = WAYS'($urandom);
        is_dirty = WAYS'($urandom);
        lru_way  = WW'($urandom);
    endtask

    // Runs one CPU transaction; r_wb / r_rf give the cycle of mem_resp (0 = never).
    task automatic run_txn(input string nm, input bit wr, input logic [WAYS-1:0] hw,
                           input logic [WAYS-1:0] vld, input logic [WAYS-1:0] drt,
                           input logic [WW-1:0] lru, input int r_wb, input int r_rf);
        outs_t           e, m;
        logic [WAYS-1:0] v_oh, h_oh;
        logic            rd;
        int              v, pc, cyc;
        bit              dirty_miss, timed_out;
        rd        = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        timed_out = 1'b0;
        cyc       = 0;

        cpu_write = wr;
        cpu_read  = rd;
        mem_resp  = 1'b0;
        scramble();
        #2;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s idle cyc%0d: got %h expected %h", nm, cyc, obs, outs_t'('0));
        end
        tick();

        cyc++;
        hit_way  = hw;
        is_valid = vld;
        is_dirty = drt;
        lru_way  = lru;
        pc       = $countones(hw);
        e        = '0;
        e.busy   = 1'b1;
        m        = loose_mask();
        if (pc > 1) begin
            e.error     = 1'b1;
            e.cpu_ready = 1'b1;
        end else if (pc == 1) begin
            e.cpu_ready  = 1'b1;
            e.lru_update = 1'b1;
            for (int i = 0; i < int'(WAYS); i++)
                if (hw[i]) e.lru_touch = WW'(i);
            m.lru_touch = '1;
            if (wr) begin
                e.load_data      = hw;
                e.set_dirty      = hw;
                m.data_in_select = 1'b1;
            end
        end
        #2;
        checks++;
        if ((obs & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s check cyc%0d: got %h expected %h", nm, cyc, obs, e);
        end
        tick();

        if (pc == 0) begin
            v          = exp_victim(vld, lru);
            v_oh       = WAYS'(1) << v;
            dirty_miss = vld[v] && drt[v];
            for (int p = dirty_miss ? 0 : 1; p < 2; p++) begin
                int r;
                r = (p == 0) ? r_wb : r_rf;
                for (int c = 1; c <= int'(TMO) + 1; c++) begin
                    cyc++;
                    scramble();
                    cpu_read  = 1'($urandom);
                    cpu_write = 1'($urandom);
                    mem_resp  = (c == r);
                    e         = '0;
                    e.busy    = 1'b1;
                    m         = loose_mask();
                    if (c != r && c == int'(TMO) + 1) begin
                        e.error     = 1'b1;
                        e.cpu_ready = 1'b1;
                        timed_out   = 1'b1;
                    end else if (p == 0) begin
                        e.mem_write = 1'b1;
                        e.wb_way    = WW'(v);
                        m.wb_way    = '1;
                    end else begin
                        e.mem_read = 1'b1;
                        if (c == r) begin
                            e.load_data      = v_oh;
                            e.load_tag       = v_oh;
                            e.set_valid      = v_oh;
                            e.clr_dirty      = v_oh;
                            e.data_in_select = 1'b1;
                            m.data_in_select = 1'b1;
                        end
                    end
                    #2;
                    checks++;
                    if ((obs & m) !== (e & m)) begin
                        errors++;
                        $display("FAIL %s mem%0d cyc%0d: got %h expected %h", nm, p, cyc, obs, e);
                    end
                    tick();
                    mem_resp = 1'b0;
                    if (c == r || timed_out) break;
                end
                if (timed_out) break;
            end

            if (!timed_out) begin
                cyc++;
                cpu_write    = wr;
                cpu_read     = rd;
                hit_way      = v_oh;
                is_valid     = WAYS'($urandom);
                is_dirty     = WAYS'($urandom);
                h_oh         = v_oh;
                e            = '0;
                e.busy       = 1'b1;
                e.cpu_ready  = 1'b1;
                e.lru_update = 1'b1;
                e.lru_touch  = WW'(v);
                m            = loose_mask();
                m.lru_touch  = '1;
                if (wr) begin
                    e.load_data      = h_oh;
                    e.set_dirty      = h_oh;
                    m.data_in_select = 1'b1;
                end
                #2;
                checks++;
                if ((obs & m) !== (e & m)) begin
                    errors++;
                    $display("FAIL %s recheck cyc%0d: got %h expected %h", nm, cyc, obs, e);
                end
                tick();
            end
        end

        // Back in IDLE; a stray mem_resp here must be ignored.
        cyc++;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        mem_resp  = 1'($urandom);
        scramble();
        #2;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s done cyc%0d: got %h expected %h", nm, cyc, obs, outs_t'('0));
        end
        tick();
        mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        mem_resp  = 1'b0;
        scramble();
        tick();
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, outs_t'('0));
        end
        tick();
    endtask

    task automatic test_hits();
        run_txn("read_hit_w2", 1'b0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 0, 0);
        run_txn("write_hit_w1", 1'b1, 4'b0010, 4'b1111, 4'b0000, 2'd3, 0, 0);
        run_txn("multi_hit", 1'b0, 4'b0011, 4'b1111, 4'b0000, 2'd0, 0, 0);
    endtask

    task automatic test_misses();
        run_txn("clean_miss", 1'b0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 0, 3);
        run_txn("dirty_miss_lru", 1'b1, 4'b0000, 4'b1111, 4'b0010, 2'd1, 2, 2);
        run_txn("invalid_dirty", 1'b1, 4'b0000, 4'b0111, 4'b1000, 2'd1, 0, 1);
        run_txn("resp_at_limit", 1'b0, 4'b0000, 4'b1111, 4'b1111, 2'd2, int'(TMO) + 1, int'(TMO) + 1);
    endtask

    task automatic test_timeout();
        run_txn("refill_timeout", 1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 0, 0);
        run_txn("wb_timeout", 1'b1, 4'b0000, 4'b1111, 4'b1111, 2'd3, 0, 0);
    endtask

    task automatic test_reset_mid();
        cpu_write = 1'b1;
        cpu_read  = 1'b0;
        tick();
        hit_way  = '0;
        is_valid = '1;
        is_dirty = '1;
        lru_way  = 2'd3;
        tick();
        #2;
        checks++;
        if (mem_write !== 1'b1 || wb_way !== 2'd3) begin
            errors++;
            $display("FAIL rst_mid_wb: got mem_write=%b wb_way=%0d expected 1 3", mem_write, wb_way);
        end
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        cpu_write = 1'b0;
        #2;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rst_mid: got %h expected %h", obs, outs_t'('0));
        end
        tick();
        #2;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rst_mid_after: got %h expected %h", obs, outs_t'('0));
        end
        tick();
    endtask

    task automatic test_random();
        logic [WAYS-1:0] hw;
        int              kind;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 4) begin
                hw = WAYS'(1) << $urandom_range(0, WAYS - 1);
            end else if (kind == 4) begin
                do hw = WAYS'($urandom); while ($countones(hw) < 2);
            end else begin
                hw = '0;
            end
            run_txn("random", 1'($urandom), hw, WAYS'($urandom), WAYS'($urandom), WW'($urandom),
                    int'($urandom_range(0, TMO + 1)), int'($urandom_range(0, TMO + 1)));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        mem_resp  = 1'b0;
        hit_way   = '0;
        is_valid  = '0;
        is_dirty  = '0;
        lru_way   = '0;
        test_reset();
        test_hits();
        test_misses();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised control FSM for the Otter data cache: an N-way set-associative, write-back, write-allocate controller. It replaces the fixed 2-way controller. It sequences tag check, dirty-victim writeback and line refill, and drives the way-indexed load/valid/dirty strobes of the cache arrays. It sits between the CPU memory port and the cache arrays / main-memory adapter, with a bounded-wait memory handshake.

## Interface
- WAYS, 2, associativity; power of two, 2..8
- WW, $clog2(WAYS), way-index width (derived, not overridden)
- MEM_TIMEOUT, 255, max cycles waiting for mem_resp before error; >=1
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- cpu_read  in  1  read request, held until cpu_ready
- cpu_write  in  1  write request, held until cpu_ready
- hit_way  in  WAYS  per-way tag match AND valid, from tag compare
- is_valid  in  WAYS  per-way valid bits of indexed set
- is_dirty  in  WAYS  per-way dirty bits of indexed set
- lru_way  in  WW  least-recently-used way of indexed set
- mem_resp  in  1  memory adapter done, one-cycle pulse
- cpu_ready  out  1  request complete, one-cycle pulse
- load_data  out  WAYS  one-hot data-array write enable
- load_tag  out  WAYS  one-hot tag-array write enable
- set_valid, set_dirty, clr_dirty  out  WAYS  one-hot state-bit strobes
- lru_update  out  1  touch LRU with lru_touch
- lru_touch  out  WW  way just accessed
- data_in_select  out  1  0 = CPU write data, 1 = memory refill data
- wb_way  out  WW  way whose tag/data feed memory during writeback
- mem_read, mem_write  out  1  memory requests, level, held until mem_resp
- busy  out  1  state != IDLE
- error  out  1  one-cycle pulse on multi-hit or timeout

## Operation
- States: IDLE, CHECK, WRITEBACK, REFILL. All outputs are decoded from the state, registered victim and inputs. Strobes are zero outside the cases listed below.
- IDLE: on cpu_write or cpu_read, latch op (write has priority if both are high) and go to CHECK. Otherwise stay.
- CHECK, hit_way one-hot at way h:
  - cpu_ready=1, lru_update=1, lru_touch=h.
  - Write op additionally: load_data[h]=1, set_dirty[h]=1, data_in_select=0.
  - Next state IDLE.
- CHECK, hit_way==0 (miss): choose the victim and register it.
  - Victim is the lowest-index way with is_valid==0.
  - If all ways are valid, victim is lru_way.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to REFILL.
- CHECK, hit_way with >1 bit set: error=1, cpu_ready=1, no array strobes, next state IDLE.
- WRITEBACK: mem_write=1, wb_way=victim. On mem_resp, reset the wait counter and go to REFILL.
- REFILL: mem_read=1. On mem_resp, in the same cycle:
  - load_data[victim]=1, load_tag[victim]=1, set_valid[victim]=1, clr_dirty[victim]=1, data_in_select=1.
  - Next state CHECK, which re-checks and now hits; a write is then merged into the refilled line.
- Wait counter: 0 on entry to WRITEBACK/REFILL, increments each cycle without mem_resp. When it reaches MEM_TIMEOUT: error=1, cpu_ready=1, mem_read/mem_write drop, no array strobes, next state IDLE. mem_resp in the same cycle as the timeout wins.
- cpu_read/cpu_write changing mid-transaction are ignored; the latched op rules.
- mem_resp outside WRITEBACK/REFILL is ignored.

## Timing
- Reset: state IDLE, victim 0, counter 0, op latch 0. All outputs 0 from the cycle after rst is sampled. rst mid-transaction aborts immediately; mem_read/mem_write drop next cycle and no strobe is issued.
- Hit latency: request sampled at edge 0; cpu_ready high during cycle 1.
- Clean miss: CHECK, then REFILL for k cycles (mem_resp in the k-th REFILL cycle), then CHECK; cpu_ready arrives k+2 cycles after acceptance.
- Dirty miss: adds j WRITEBACK cycles.
- cpu_ready is a pulse; the CPU must drop its request the cycle after cpu_ready. A request still high in IDLE starts a new transaction.
- Victim choice is registered at the end of CHECK. is_valid/is_dirty/lru_way are only sampled in CHECK.

## Test plan
- WAYS=4, read, hit_way=4'b0100 -> cpu_ready in cycle 1, lru_update=1, lru_touch=2, load_data=0.
- WAYS=4, write hit way 1 -> load_data=4'b0010, set_dirty=4'b0010, data_in_select=0, cpu_ready in cycle 1.
- WAYS=4, read miss, is_valid=4'b1011, mem_resp after 3 cycles -> REFILL 3 cycles, load_tag=4'b0100, set_valid=4'b0100, then hit, cpu_ready at cycle 5.
- WAYS=2, write miss, all valid, lru_way=1, is_dirty=2'b10 -> mem_write with wb_way=1, then mem_read, refill way 1 with clr_dirty, re-check, load_data=2'b10 with set_dirty.
- MEM_TIMEOUT=4, miss with no mem_resp -> mem_read for 4 cycles, then error and cpu_ready pulse together, IDLE, no load_data.
- hit_way=4'b0011 -> error=1, cpu_ready=1, no strobes. Separately, rst asserted in WRITEBACK -> IDLE, all outputs 0 next cycle.
